// File: rtl/qk_inst_seq_pkg.sv
// rtl/qk_inst_seq_pkg.sv - shared states, inst bit map and SFP step constants
package qk_inst_seq_pkg;

    localparam int INST_W = 19;
    localparam int ADDR_W = 4;

    localparam int DIV_READY_BIT = 18;
    localparam int ACC_READY_BIT = 17;
    localparam int OFIFO_RD_BIT  = 16;
    localparam int QKMEM_ADD_LSB = 12;
    localparam int PMEM_ADD_LSB  = 8;
    localparam int EXECUTE_BIT   = 7;
    localparam int LOAD_BIT      = 6;
    localparam int QMEM_RD_BIT   = 5;
    localparam int QMEM_WR_BIT   = 4;
    localparam int KMEM_RD_BIT   = 3;
    localparam int KMEM_WR_BIT   = 2;
    localparam int PMEM_RD_BIT   = 1;
    localparam int PMEM_WR_BIT   = 0;

    localparam int SFP_STEPS     = 6;
    localparam int SFP_ACC_FIRST = 1;
    localparam int SFP_ACC_LAST  = 2;
    localparam int SFP_DIV_FIRST = 4;
    localparam int SFP_DIV_LAST  = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_QWR, S_KWR, S_GAP, S_KLOAD, S_KEND, S_WAIT1,
        S_EXEC, S_WAIT2, S_OFIFO, S_SFP, S_TAIL, S_DONE
    } state_t;

    typedef struct packed {
        logic              div_ready;
        logic              acc_ready;
        logic              ofifo_rd;
        logic [ADDR_W-1:0] qkmem_add;
        logic [ADDR_W-1:0] pmem_add;
        logic              execute;
        logic              load;
        logic              qmem_rd;
        logic              qmem_wr;
        logic              kmem_rd;
        logic              kmem_wr;
        logic              pmem_rd;
        logic              pmem_wr;
    } inst_fields_t;

    function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
        logic [INST_W-1:0] w;
        w = '0;
        w[DIV_READY_BIT]                = f.div_ready;
        w[ACC_READY_BIT]                = f.acc_ready;
        w[OFIFO_RD_BIT]                 = f.ofifo_rd;
        w[QKMEM_ADD_LSB +: ADDR_W]      = f.qkmem_add;
        w[PMEM_ADD_LSB +: ADDR_W]       = f.pmem_add;
        w[EXECUTE_BIT]                  = f.execute;
        w[LOAD_BIT]                     = f.load;
        w[QMEM_RD_BIT]                  = f.qmem_rd;
        w[QMEM_WR_BIT]                  = f.qmem_wr;
        w[KMEM_RD_BIT]                  = f.kmem_rd;
        w[KMEM_WR_BIT]                  = f.kmem_wr;
        w[PMEM_RD_BIT]                  = f.pmem_rd;
        w[PMEM_WR_BIT]                  = f.pmem_wr;
        return w;
    endfunction

endpackage

// File: rtl/qk_inst_seq_if.sv
// rtl/qk_inst_seq_if.sv - row input, fifo status and core instruction bundle
interface qk_inst_seq_if
    import qk_inst_seq_pkg::*;
#(
    parameter int pr = 16,
    parameter int bw = 4
);
    logic [pr*bw-1:0]  data_in;
    logic              data_valid;
    logic              data_ready;
    logic              fifo_valid;
    logic [pr*bw-1:0]  mem_in;
    logic [INST_W-1:0] inst;

    modport master (
        output data_in, data_valid, fifo_valid,
        input  data_ready, mem_in, inst
    );

    modport slave (
        input  data_in, data_valid, fifo_valid,
        output data_ready, mem_in, inst
    );
endinterface

// File: rtl/qk_inst_seq.sv
// rtl/qk_inst_seq.sv - sequencer driving the QK core through load, execute and SFP
module qk_inst_seq
    import qk_inst_seq_pkg::*;
#(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int pr          = 16,
    parameter int bw          = 4,
    parameter int wait_cyc    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    qk_inst_seq_if.slave        bus,
    output logic                busy,
    output logic                done
);

    localparam int ROW_W = pr * bw;
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] Q_LAST     = ADDR_W'(total_cycle - 1);
    localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(col - 1);
    localparam logic [ADDR_W-1:0] KLOAD_LAST = ADDR_W'(col);
    localparam logic [ADDR_W-1:0] WAIT_LAST  = ADDR_W'(wait_cyc - 1);
    localparam logic [2:0] SFP_LAST  = 3'(SFP_STEPS - 1);
    localparam logic [2:0] ACC_FIRST = 3'(SFP_ACC_FIRST);
    localparam logic [2:0] ACC_LAST  = 3'(SFP_ACC_LAST);
    localparam logic [2:0] DIV_FIRST = 3'(SFP_DIV_FIRST);
    localparam logic [2:0] DIV_LAST  = 3'(SFP_DIV_LAST);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [2:0]        step_q, step_d;
    inst_fields_t      f;
    logic              accept;
    logic [INST_W-1:0] inst_q;
    logic [ROW_W-1:0]  mem_in_q;
    logic              busy_q, done_q;

    assign bus.data_ready = (state_q == S_QWR) || (state_q == S_KWR);
    assign accept         = bus.data_ready && bus.data_valid;
    assign bus.inst       = inst_q;
    assign bus.mem_in     = mem_in_q;
    assign busy           = busy_q;
    assign done           = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + ONE;
        step_d  = step_q;
        f       = '0;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_QWR;
            S_QWR, S_KWR: begin
                cnt_d = cnt_q;
                if (accept) begin
                    f.qmem_wr   = (state_q == S_QWR);
                    f.kmem_wr   = (state_q == S_KWR);
                    f.qkmem_add = cnt_q;
                    cnt_d       = cnt_q + ONE;
                    if (state_q == S_QWR && cnt_q == Q_LAST) state_d = S_KWR;
                    if (state_q == S_KWR && cnt_q == K_LAST) state_d = S_GAP;
                end
            end
            S_GAP:   if (cnt_q == ONE) state_d = S_KLOAD;
            S_KLOAD: begin
                // first two load cycles share address 0; later ones trail k by one
                f.load      = 1'b1;
                f.kmem_rd   = (cnt_q != '0);
                f.qkmem_add = (cnt_q <= ONE) ? '0 : cnt_q - ONE;
                if (cnt_q == KLOAD_LAST) state_d = S_KEND;
            end
            S_KEND: begin
                f.load  = 1'b1;
                state_d = S_WAIT1;
            end
            S_WAIT1: if (cnt_q == WAIT_LAST) state_d = S_EXEC;
            S_EXEC: begin
                f.execute   = 1'b1;
                f.qmem_rd   = 1'b1;
                f.qkmem_add = cnt_q;
                if (cnt_q == Q_LAST) state_d = S_WAIT2;
            end
            S_WAIT2: if (cnt_q == WAIT_LAST) state_d = S_OFIFO;
            S_OFIFO: begin
                cnt_d = cnt_q;
                if (bus.fifo_valid) begin
                    f.ofifo_rd = 1'b1;
                    f.pmem_wr  = 1'b1;
                    f.pmem_add = cnt_q;
                    cnt_d      = cnt_q + ONE;
                    if (cnt_q == Q_LAST) state_d = S_SFP;
                end
            end
            S_SFP: begin
                f.pmem_rd   = 1'b1;
                f.pmem_add  = cnt_q;
                f.acc_ready = (step_q >= ACC_FIRST) && (step_q <= ACC_LAST);
                f.div_ready = (step_q >= DIV_FIRST) && (step_q <= DIV_LAST);
                if (step_q == SFP_LAST) begin
                    step_d = '0;
                    if (cnt_q == Q_LAST) state_d = S_TAIL;
                end else begin
                    step_d = step_q + 3'd1;
                    cnt_d  = cnt_q;
                end
            end
            S_TAIL: begin
                f.div_ready = 1'b1;
                if (cnt_q == ONE) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            step_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            inst_q  <= pack_inst(f);
            if (accept) mem_in_q <= bus.data_in;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_DONE);
        end
    end

endmodule

// File: doc/qk_inst_seq.md
QK_INST_SEQ -- requirements
Module: qk_inst_seq

Interface
REQ-001 SHALL have parameters: total_cycle 8 (Q rows); col 8 (K rows); pr 16 (lanes per row); bw 4 (element bits); wait_cyc 10 (settle gap).
REQ-002 SHALL have port: clk  in  1  single clock, all flops on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low; one clock, active-low asynchronous reset.
REQ-004 SHALL have port: start  in  1  one-cycle request to run the full sequence.
REQ-005 SHALL have port: data_in  in  pr*bw  Q rows, then K rows, lane j in bits [(j+1)*bw-1 : j*bw].
REQ-006 SHALL have port: data_valid  in  1  data_in holds a valid row.
REQ-007 SHALL have port: data_ready  out  1  the block consumes the row this cycle.
REQ-008 SHALL have port: fifo_valid  in  1  core output FIFO is not empty.
REQ-009 SHALL have port: mem_in  out  pr*bw  registered copy of the accepted row.
REQ-010 SHALL have port: inst  out  19  core instruction word.
- Bit map: [18] div_ready, [17] acc_ready, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-011 SHALL have ports: busy  out  1  sequence active; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL register inst, mem_in, busy and done; all outputs change only on the rising clk edge.
REQ-013 SHALL sample start only in IDLE; the first QWR instruction appears on the next edge.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL step through states in order: IDLE, QWR, KWR, GAP, KLOAD, KEND, WAIT1, EXEC, WAIT2, OFIFO, SFP, TAIL, DONE, IDLE.
REQ-016 QWR: SHALL assert data_ready=1 and, per accepted row (data_valid&data_ready), emit qmem_wr=1 with qkmem_add=0..total_cycle-1 and mem_in=row.
- A cycle with data_valid=0 emits inst=0 and holds the address.
REQ-017 KWR: SHALL behave like QWR but with kmem_wr=1 for col rows and qkmem_add restarting at 0.
REQ-018 GAP: SHALL hold inst=0 for 2 cycles.
REQ-019 KLOAD: SHALL run col+1 cycles k=0..col with load=1.
- kmem_rd=1 for k>=1.
- qkmem_add=0 for k<=1, else k-1.
REQ-020 KEND: SHALL run 1 cycle with load=1, kmem_rd=0, qkmem_add=0.
REQ-021 WAIT1 and WAIT2: SHALL each run wait_cyc cycles with inst=0.
REQ-022 EXEC: SHALL run total_cycle cycles with execute=1, qmem_rd=1, qkmem_add=0..total_cycle-1.
REQ-023 OFIFO: SHALL assert ofifo_rd=1 and pmem_wr=1 only in cycles where fifo_valid=1.
- pmem_add advances 0..total_cycle-1 only on those cycles.
- A stall cycle emits inst=0.
REQ-024 SFP: for each row t=0..total_cycle-1, SHALL run a 6-step sub-sequence s=0..5 with pmem_rd=1 and pmem_add=t.
- acc_ready=1 for s in {1,2}.
- div_ready=1 for s in {4,5}.
REQ-025 TAIL: SHALL run 2 cycles with div_ready=1, pmem_rd=0, pmem_add=0.
REQ-026 DONE: SHALL drive inst=0 and done=1 for exactly 1 cycle.
REQ-027 SHALL hold busy=1 in every state except IDLE.
REQ-028 SHALL make a full unstalled run last exactly 114 cycles from the first QWR to the last TAIL, with DONE on the 115th.
REQ-029 SHALL hold all address counters at 4 bits and clear them on every state entry; wrap is impossible with the default parameters.
REQ-030 SHALL assert data_ready only in QWR/KWR, and SHALL deassert it in the cycle after the last row is accepted.

Reset
REQ-031 While reset=0, SHALL drive inst=0, mem_in=0, busy=0, done=0, data_ready=0, all counters 0, state=IDLE, asynchronously.
REQ-032 Reset asserted mid-sequence SHALL abort immediately with no partial instruction; after release, the block waits for a new start.

Structure
REQ-033 A shared package SHALL hold the state enum, the inst bit-position constants (19-bit width) and the SFP step constants (6 steps, acc steps 1-2, div steps 4-5).
REQ-034 SHALL be one module with no sub-module; the inst word SHALL be assembled by a package function from the field values.

Verification
REQ-035 Reset check: reset=0 in the middle of EXEC (row 3) -> inst=0 and busy=0 within the same cycle; after release and a new start, row Q0 is accepted with qkmem_add=0.
REQ-036 Unstalled full run: start, data_valid=1 continuously, fifo_valid=1 -> 8 qmem_wr, then 8 kmem_wr, then the KLOAD addresses 0,0,1..7, then done exactly 115 cycles after the first QWR; inst matches the bit map every cycle.
REQ-037 Data stall: data_valid low for 3 cycles during Q row 4 -> inst=0 for those cycles, qkmem_add holds at 4, and 3 cycles are added to the run.
REQ-038 FIFO stall: fifo_valid=0 for 2 cycles before pmem_add 5 -> no ofifo_rd and no pmem_wr in those cycles, with exactly 8 pmem_wr in total.
REQ-039 start pulsed during EXEC -> ignored; exactly one done pulse is produced.
REQ-040 SFP row 2 -> 6 cycles with pmem_add=2, where acc_ready is 0,1,1,0,0,0 and div_ready is 0,0,0,0,1,1.
